muldiv_unit: RTL
================

# muldiv_unit

Iterative RV64M multiply/divide unit that sits directly downstream of `register_file`. It consumes the register file's two read operands, `data_a` (rs1) and `data_b` (rs2), and computes the M-extension result over several cycles. It then writes the result back through the register file's write port, `write_en`/`write_addr`/`write_data`. A simple start/busy handshake lets the control path stall while an operation is in flight.

## Interface
- `WORDSIZE`, 64, operand/result width; iteration count equals `WORDSIZE`
- `clk`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-low reset; sampled on rising edge of `clk`
- `start`  in  1  request; accepted only in IDLE
- `op`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `rd_in`  in  5  destination register index
- `rs1_data`  in  WORDSIZE  operand A, from register file `data_a`
- `rs2_data`  in  WORDSIZE  operand B, from register file `data_b`
- `busy`  out  1  high from the cycle after acceptance through the write cycle
- `write_en`  out  1  one-cycle write strobe to the register file
- `write_addr`  out  5  destination index, valid with `write_en`
- `write_data`  out  WORDSIZE  result, valid with `write_en`

## Operation
- States are IDLE, CALC, FIX and DONE. All outputs are registered.
- IDLE:
  - On `start`=1, latch `op`, `rd_in` and operand magnitudes plus sign flags.
  - Sign rules per op: MULH, DIV and REM treat both operands as signed. MULHSU treats rs1 as signed and rs2 as unsigned. The other ops are unsigned; MUL signedness is irrelevant.
  - Special cases go to DONE; everything else goes to CALC with the iteration counter set to `WORDSIZE`-1.
- Special cases, which skip CALC:
  - Divisor zero: DIV/DIVU return all ones; REM/REMU return the dividend.
  - Signed overflow, DIV of 0x8000…0 by −1: returns 0x8000…0; REM returns 0.
- CALC, one iteration per cycle for `WORDSIZE` cycles:
  - Multiply: shift-add over a 2·`WORDSIZE` accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder magnitudes.
  - When the counter reaches 0, go to FIX.
- FIX:
  - Product negated if the operand signs differ.
  - Quotient negated if the signs differ; remainder takes the dividend's sign.
  - Select the result: MUL takes the low half, MULH* the high half, DIV* the quotient, REM* the remainder.
  - Go to DONE.
- DONE:
  - Drive `write_data`/`write_addr`.
  - `write_en`=1 unless `write_addr`=0. The register file has no x0 guard, so this unit must never write x0.
  - Return to IDLE.
- `start` while `busy` is ignored, and the in-flight operation is unaffected.

## Timing
- Acceptance edge t (IDLE, `start`=1).
- Normal op:
  - CALC occupies t+1…t+64, FIX t+65, DONE t+66.
  - `write_en` is high during cycle t+66; `busy` is high during t+1…t+66.
- Special case: DONE at t+1, with `write_en` and `busy` high during t+1 only.
- Earliest next acceptance is the cycle after DONE (t+67 normal, t+2 special). There is no overlap.
- `write_data`/`write_addr` hold their last value outside DONE; consumers qualify them with `write_en`.
- Reset (`reset`=0 at an edge):
  - Next state is IDLE.
  - `busy`=0, `write_en`=0, `write_addr`=0, `write_data`=0, counter 0.
  - Any in-flight op is discarded with no write. Reset takes priority over `start`.

## Structure
- Shared package `muldiv_pkg` holds:
  - the op funct3 constants;
  - the state encoding (IDLE, CALC, FIX, DONE);
  - the signed-overflow constant 0x8000…0 expressed in `WORDSIZE`.
- Single module with no sub-module. Datapath registers: 2·`WORDSIZE` accumulator/remainder, `WORDSIZE` multiplier/divisor, counter of clog2(`WORDSIZE`) bits, latched op/rd/sign flags.

## Test plan
- MUL rs1=7, rs2=0xFFFF_FFFF_FFFF_FFFD, rd=5 -> `write_en` at t+66, `write_addr`=5, `write_data`=0xFFFF_FFFF_FFFF_FFEB.
- MULHU all-ones × all-ones -> 0xFFFF_FFFF_FFFF_FFFE; MULH same operands -> 0; MULHSU rs1=−1, rs2=2 -> 0xFFFF_FFFF_FFFF_FFFF.
- DIV −7/2 -> 0xFFFF_FFFF_FFFF_FFFD; REM −7/2 -> 0xFFFF_FFFF_FFFF_FFFF; DIVU 100/7 -> 14, REMU -> 2.
- DIVU 5/0 -> all ones at t+1; REMU 5/0 -> 5; DIV 0x8000_0000_0000_0000/−1 -> same value at t+1; REM -> 0.
- Two cases in one scenario:
  - `start` pulsed at t+10 with different operands -> ignored, original result at t+66, next acceptance at t+67.
  - rd=0 -> `busy` behaves normally, `write_en` stays 0.
- `reset`=0 during CALC cycle t+30 -> next cycle IDLE, `busy`=0, no `write_en` ever for that op; a subsequent MUL 3×4 completes with 12.

Source files
------------

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants and state encoding for the RV64M multiply/divide unit
package muldiv_pkg;

  localparam int WORDSIZE = 64;
  localparam int CNT_W    = $clog2(WORDSIZE);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [WORDSIZE-1:0] SIGNED_OVF = {1'b1, {(WORDSIZE-1){1'b0}}};

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - start/busy request and register-file write-back bundle
interface muldiv_if import muldiv_pkg::*; ();

  logic                start;
  logic [2:0]          op;
  logic [4:0]          rd_in;
  logic [WORDSIZE-1:0] rs1_data;
  logic [WORDSIZE-1:0] rs2_data;
  logic                busy;
  logic                write_en;
  logic [4:0]          write_addr;
  logic [WORDSIZE-1:0] write_data;

  modport master (
    output start, op, rd_in, rs1_data, rs2_data,
    input  busy, write_en, write_addr, write_data
  );

  modport slave (
    input  start, op, rd_in, rs1_data, rs2_data,
    output busy, write_en, write_addr, write_data
  );

endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV64M multiply/divide with register-file write-back
module muldiv_unit import muldiv_pkg::*; (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam int W = WORDSIZE;

  state_e             state_q, state_d;
  logic [2*W-1:0]     acc_q, acc_d;
  logic [W-1:0]       opb_q, opb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [4:0]         rd_q, rd_d;
  logic               neg_q, neg_d;
  logic               sa_q, sa_d;
  logic               busy_q, busy_d;
  logic               we_q, we_d;
  logic [4:0]         waddr_q, waddr_d;
  logic [W-1:0]       wdata_q, wdata_d;

  logic               signed_a, signed_b, sa, sb;
  logic [W-1:0]       mag_a, mag_b;
  logic               div_zero, div_ovf;
  logic [W-1:0]       special_res;
  logic [W:0]         mul_sum;
  logic [2*W-1:0]     mul_next;
  logic [W:0]         div_tmp, div_rem;
  logic               div_ge;
  logic [2*W-1:0]     div_next;
  logic [2*W-1:0]     prod;
  logic [W-1:0]       quot_mag, rem_mag, result;

  always_comb begin
    signed_a = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
               (bus.op == OP_DIV)  || (bus.op == OP_REM);
    signed_b = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
    sa       = signed_a && bus.rs1_data[W-1];
    sb       = signed_b && bus.rs2_data[W-1];
    mag_a    = sa ? -bus.rs1_data : bus.rs1_data;
    mag_b    = sb ? -bus.rs2_data : bus.rs2_data;
    div_zero = bus.op[2] && (bus.rs2_data == '0);
    div_ovf  = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
               (bus.rs1_data == SIGNED_OVF) && (bus.rs2_data == {W{1'b1}});
    // op[1] separates REM* from DIV* within the divide group
    if (bus.op[1]) special_res = div_zero ? bus.rs1_data : '0;
    else           special_res = div_zero ? {W{1'b1}} : SIGNED_OVF;
  end

  // One shift-add or restoring shift-subtract step on the accumulator
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[W-1:1]};
    div_tmp  = acc_q[2*W-1:W-1];
    div_ge   = div_tmp >= {1'b0, opb_q};
    div_rem  = div_ge ? (div_tmp - {1'b0, opb_q}) : div_tmp;
    div_next = {div_rem[W-1:0], acc_q[W-2:0], div_ge};
  end

  always_comb begin
    prod     = neg_q ? -acc_q : acc_q;
    quot_mag = acc_q[W-1:0];
    rem_mag  = acc_q[2*W-1:W];
    case (op_q)
      OP_MUL:                        result = prod[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result = prod[2*W-1:W];
      OP_DIV, OP_DIVU:               result = neg_q ? -quot_mag : quot_mag;
      default:                       result = sa_q ? -rem_mag : rem_mag;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    neg_d   = neg_q;
    sa_d    = sa_q;
    busy_d  = busy_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d   = bus.op;
          rd_d   = bus.rd_in;
          busy_d = 1'b1;
          if (div_zero || div_ovf) begin
            wdata_d = special_res;
            waddr_d = bus.rd_in;
            we_d    = (bus.rd_in != 5'd0);
            state_d = S_DONE;
          end else begin
            acc_d   = {{W{1'b0}}, mag_a};
            opb_d   = mag_b;
            cnt_d   = CNT_W'(W - 1);
            neg_d   = sa ^ sb;
            sa_d    = sa;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = op_q[2] ? div_next : mul_next;
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX: begin
        wdata_d = result;
        waddr_d = rd_q;
        we_d    = (rd_q != 5'd0);
        state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      sa_q    <= 1'b0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      neg_q   <= neg_d;
      sa_q    <= sa_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.write_en   = we_q;
  assign bus.write_addr = waddr_q;
  assign bus.write_data = wdata_q;

endmodule
